// File: rtl/board_io_pkg.sv
// Shared types, constants and counter-width helper for the board input conditioner.
package board_io_pkg;

  typedef enum logic [1:0] {RELEASED, HELD_DELAY, HELD_REPEAT} chan_state_t;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_10MS = 500_000;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioned input: synchroniser, polarity fix, debounce, edge pulses, auto-repeat.
module input_channel
  import board_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter bit          POLARITY        = 1'b1,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcntW  = cnt_width(RepMax);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   n_cur;
  logic                   level_cur;
  logic                   level_nxt;
  logic                   rise;
  logic                   fall;

  // Reset to the inactive raw level so a held input is seen as a fresh press.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{POLARITY}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign n_cur = sync_q[SYNC_STAGES-1] ^ POLARITY;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // Level is the last sync flop; its next value comes from the stage before.
    assign level_cur = n_cur;
    assign level_nxt = sync_q[SYNC_STAGES-2] ^ POLARITY;
  end else begin : g_debounce
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (n_cur == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = n_cur;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level_cur = level_q;
    assign level_nxt = level_d;
  end

  assign rise      = level_nxt & ~level_cur;
  assign fall      = ~level_nxt & level_cur;
  assign level_out = level_cur;

  chan_state_t      state_q;
  logic [RcntW-1:0] rcnt_q;

  // Accepted level edges take priority, so repeat never overlaps press or release.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      state_q       <= RELEASED;
      rcnt_q        <= '0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      repeat_pulse  <= 1'b0;
      if (fall) begin
        state_q <= RELEASED;
        rcnt_q  <= '0;
      end else if (rise && REPEAT_EN) begin
        state_q <= HELD_DELAY;
        rcnt_q  <= '0;
      end else begin
        unique case (state_q)
          RELEASED: rcnt_q <= '0;
          HELD_DELAY: begin
            if (rcnt_q == RcntW'(REPEAT_DELAY - 1)) begin
              repeat_pulse <= 1'b1;
              rcnt_q       <= '0;
              state_q      <= HELD_REPEAT;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          HELD_REPEAT: begin
            if (rcnt_q == RcntW'(REPEAT_PERIOD - 1)) begin
              repeat_pulse <= 1'b1;
              rcnt_q       <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: state_q <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions DE1-SoC keys/switches: N_CH independent channels plus a combined event flag.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned     N_CH            = 4,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter logic [N_CH-1:0] POLARITY_MASK   = '1,
  parameter logic [N_CH-1:0] REPEAT_EN       = '0,
  parameter int unsigned     REPEAT_DELAY    = 25_000_000,
  parameter int unsigned     REPEAT_PERIOD   = 5_000_000
) (
  input  logic            clock_50,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_event
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .POLARITY       (POLARITY_MASK[i]),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_chan (
      .clock_50     (clock_50),
      .reset_n      (reset_n),
      .raw_in       (raw_in[i]),
      .level_out    (level_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign any_event = |{press_pulse, release_pulse, repeat_pulse};

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events, a monitor pops them on any_event.
module tb_board_input_conditioner;

  logic       clock_50 = 1'b0;
  logic       reset_n  = 1'b1;
  logic [3:0] raw_in   = 4'b1111;
  logic [3:0] level_out, press_pulse, release_pulse, repeat_pulse;
  logic       any_event;

  board_input_conditioner #(
    .N_CH           (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .POLARITY_MASK  (4'b1111),
    .REPEAT_EN      (4'b0011),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock_50     (clock_50),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .any_event    (any_event)
  );

  always #5 clock_50 = ~clock_50;

  int cyc = 0;
  always @(posedge clock_50) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] rp;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] rp);
    ev_t e;
    e.at = at;
    e.p  = p;
    e.r  = r;
    e.rp = rp;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock_50);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any pulse activity must match the scoreboard head in cycle and content.
  always @(negedge clock_50) begin
    ev_t e;
    if (sb.size() > 0 && sb[0].at < cyc) begin
      n_checks++;
      n_err++;
      $display("FAIL missed_event: expected at cycle %0d p=%b r=%b rp=%b, nothing seen",
               sb[0].at, sb[0].p, sb[0].r, sb[0].rp);
      void'(sb.pop_front());
    end
    if (any_event || (press_pulse | release_pulse | repeat_pulse) != 4'b0) begin
      n_checks++;
      if (sb.size() == 0 || sb[0].at != cyc) begin
        n_err++;
        $display("FAIL unexpected_event: cycle %0d any=%b p=%b r=%b rp=%b, none expected",
                 cyc, any_event, press_pulse, release_pulse, repeat_pulse);
      end else begin
        e = sb.pop_front();
        if (press_pulse !== e.p || release_pulse !== e.r || repeat_pulse !== e.rp ||
            any_event !== 1'b1) begin
          n_err++;
          $display("FAIL event_content: cycle %0d got any=%b p=%b r=%b rp=%b expected p=%b r=%b rp=%b",
                   cyc, any_event, press_pulse, release_pulse, repeat_pulse, e.p, e.r, e.rp);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int p;
    int r;

    // Reset idle with all keys up.
    #1 reset_n = 1'b0;
    #2 check("reset_async", {level_out, press_pulse, release_pulse, repeat_pulse, any_event}, 0);
    repeat (3) @(negedge clock_50);
    check("reset_clocked", {level_out, press_pulse, release_pulse, repeat_pulse, any_event}, 0);
    reset_n = 1'b1;
    t = cyc;
    wait_until(t + 20);
    check("idle_level", level_out, 4'b0000);

    // Clean press on ch0, auto-repeat while held, then release.
    t = cyc;
    raw_in[0] = 1'b0;
    p = t + 6;
    expect_ev(p, 4'b0001, 4'b0000, 4'b0000);
    for (int k = 0; k < 6; k++) expect_ev(p + 8 + 3 * k, 4'b0000, 4'b0000, 4'b0001);
    wait_until(p - 1);
    check("ch0_level_before", level_out, 4'b0000);
    wait_until(p + 1);
    check("ch0_level_held", level_out, 4'b0001);
    wait_until(p + 18);
    raw_in[0] = 1'b1;
    expect_ev(p + 24, 4'b0000, 4'b0001, 4'b0000);
    wait_until(p + 36);
    check("ch0_level_released", level_out, 4'b0000);

    // Bouncing ch1: only the final stable low is accepted; release lands on a would-be repeat.
    t = cyc;
    raw_in[1] = 1'b0;
    wait_until(t + 3); raw_in[1] = 1'b1;
    wait_until(t + 4); raw_in[1] = 1'b0;
    wait_until(t + 6); raw_in[1] = 1'b1;
    wait_until(t + 7); raw_in[1] = 1'b0;
    expect_ev(t + 13, 4'b0010, 4'b0000, 4'b0000);
    wait_until(t + 15);
    raw_in[1] = 1'b1;
    expect_ev(t + 21, 4'b0000, 4'b0010, 4'b0000);
    wait_until(t + 30);

    // ch2 has no auto-repeat.
    t = cyc;
    raw_in[2] = 1'b0;
    expect_ev(t + 6, 4'b0100, 4'b0000, 4'b0000);
    wait_until(t + 40);
    check("ch2_level_held", level_out, 4'b0100);
    raw_in[2] = 1'b1;
    expect_ev(t + 46, 4'b0000, 4'b0100, 4'b0000);
    wait_until(t + 55);

    // Simultaneous press and release on ch0 and ch3.
    t = cyc;
    raw_in[0] = 1'b0;
    raw_in[3] = 1'b0;
    expect_ev(t + 6, 4'b1001, 4'b0000, 4'b0000);
    expect_ev(t + 14, 4'b0000, 4'b0000, 4'b0001);
    wait_until(t + 7);
    check("dual_level", level_out, 4'b1001);
    check("dual_any_one_cycle", any_event, 1'b0);
    wait_until(t + 10);
    raw_in[0] = 1'b1;
    raw_in[3] = 1'b1;
    expect_ev(t + 16, 4'b0000, 4'b1001, 4'b0000);
    wait_until(t + 30);

    // Reset while ch0 is repeating, then re-press from the still-held key.
    t = cyc;
    raw_in[0] = 1'b0;
    expect_ev(t + 6, 4'b0001, 4'b0000, 4'b0000);
    expect_ev(t + 14, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(t + 17, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(t + 20, 4'b0000, 4'b0000, 4'b0001);
    wait_until(t + 20);
    check("pre_reset_level", level_out, 4'b0001);
    #2 reset_n = 1'b0;
    #1 check("midhold_reset_async",
             {level_out, press_pulse, release_pulse, repeat_pulse, any_event}, 0);
    repeat (2) @(negedge clock_50);
    reset_n = 1'b1;
    r = cyc;
    expect_ev(r + 6, 4'b0001, 4'b0000, 4'b0000);
    expect_ev(r + 14, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(r + 17, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(r + 20, 4'b0000, 4'b0000, 4'b0001);
    wait_until(r + 15);
    raw_in[0] = 1'b1;
    expect_ev(r + 21, 4'b0000, 4'b0001, 4'b0000);
    wait_until(r + 35);

    check("scoreboard_drained", sb.size(), 0);
    check("final_level", level_out, 4'b0000);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
